// File: rtl/division_operand_framer.sv
// Frames a Q4.4 byte stream into (dividend, divisor) pairs for a downstream divider.
// A partial frame is discarded with a one-cycle o_timeout pulse when the divisor is late.
module division_operand_framer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [7:0] o_dividend,
    output logic [7:0] o_divisor,
    output logic       o_div_by_zero,
    output logic       o_timeout,
    output logic [7:0] o_frame_count,
    output logic [1:0] o_fsm_state
);

    typedef enum logic [1:0] {
        WAIT_DIVIDEND = 2'd0,
        WAIT_DIVISOR  = 2'd1,
        PRESENT       = 2'd2
    } state_t;

    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_dividend_pend;
    logic [7:0] r_dividend;
    logic [7:0] r_divisor;
    logic       r_div_by_zero;
    logic       r_valid;
    logic       r_timeout;
    logic [7:0] r_frame_count;
    logic [7:0] r_idle;

    logic       w_ready;
    logic       w_accept;
    logic       w_handshake;

    // Upstream: a byte moves on a rising edge with i_valid && o_ready.
    // Downstream: the pair moves on a rising edge with o_valid && i_ready;
    // o_valid and the pair hold steady until that edge.
    assign w_ready     = i_reset_n && (r_state != PRESENT);
    assign w_accept    = i_valid && w_ready;
    assign w_handshake = r_valid && i_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= WAIT_DIVIDEND;
            r_dividend_pend <= 8'h00;
            r_dividend      <= 8'h00;
            r_divisor       <= 8'h00;
            r_div_by_zero   <= 1'b0;
            r_valid         <= 1'b0;
            r_timeout       <= 1'b0;
            r_frame_count   <= 8'h00;
            r_idle          <= 8'h00;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                WAIT_DIVIDEND: begin
                    if (w_accept) begin
                        r_dividend_pend <= i_data;
                        r_idle          <= 8'h00;
                        r_state         <= WAIT_DIVISOR;
                    end
                end
                WAIT_DIVISOR: begin
                    // An accept on the threshold cycle takes priority over the timeout.
                    if (w_accept) begin
                        r_dividend    <= r_dividend_pend;
                        r_divisor     <= i_data;
                        r_div_by_zero <= (i_data == 8'h00);
                        r_valid       <= 1'b1;
                        r_idle        <= 8'h00;
                        r_state       <= PRESENT;
                    end else if (r_idle == IDLE_LAST) begin
                        r_timeout <= 1'b1;
                        r_idle    <= 8'h00;
                        r_state   <= WAIT_DIVIDEND;
                    end else begin
                        r_idle <= r_idle + 8'd1;
                    end
                end
                PRESENT: begin
                    if (w_handshake) begin
                        r_valid       <= 1'b0;
                        r_frame_count <= r_frame_count + 8'd1;
                        r_state       <= WAIT_DIVIDEND;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= WAIT_DIVIDEND;
                end
            endcase
        end
    end

    assign o_ready       = w_ready;
    assign o_valid       = r_valid;
    assign o_dividend    = r_dividend;
    assign o_divisor     = r_divisor;
    assign o_div_by_zero = r_div_by_zero;
    assign o_timeout     = r_timeout;
    assign o_frame_count = r_frame_count;
    assign o_fsm_state   = r_state;

endmodule

// File: tb/tb_division_operand_framer.sv
// Bench for division_operand_framer: vector table, timeout/threshold/stray-byte/reset
// sequences, and a scoreboard that checks every downstream handshake.
module tb_division_operand_framer;

    localparam int         TO    = 12;
    localparam logic [1:0] S_WDD = 2'd0;
    localparam logic [1:0] S_WDS = 2'd1;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_data  = 8'h00;
    logic       i_ready = 1'b0;
    logic       o_ready, o_valid, o_div_by_zero, o_timeout;
    logic [7:0] o_dividend, o_divisor, o_frame_count;
    logic [1:0] o_fsm_state;

    division_operand_framer #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
        .o_dividend(o_dividend), .o_divisor(o_divisor), .o_div_by_zero(o_div_by_zero),
        .o_timeout(o_timeout), .o_frame_count(o_frame_count), .o_fsm_state(o_fsm_state)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_tmo = 0;
    logic [16:0] exp_q[$];   // {div_by_zero, dividend, divisor}
    logic [7:0]  exp_cnt = 8'h00;
    logic [16:0] mon_e;

    typedef struct {
        logic [7:0] dividend;
        logic [7:0] divisor;
        int         gap;
        int         hold;
        logic       exp_dbz;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string detail);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int w = 0;
        while (o_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        if (o_ready !== 1'b1) fail_now("ready_wait", "o_ready still low after 50 cycles, required 1");
        i_valid = 1'b1;
        i_data  = d;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int gap);
        send_byte(a);
        repeat (gap) tick();
        exp_q.push_back({(b == 8'h00), a, b});
        send_byte(b);
    endtask

    task automatic await_drain();
        int w = 0;
        i_ready = 1'b1;
        while (exp_q.size() != 0 && w < 50) begin
            tick();
            w++;
        end
        if (exp_q.size() != 0) fail_now("drain_wait", "no handshake within 50 cycles");
        i_ready = 1'b0;
    endtask

    // Scoreboard: a handshake is due on the next edge whenever o_valid && i_ready here.
    always @(negedge clk) begin
        if (o_timeout === 1'b1) n_tmo++;
        if (rst_n && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_handshake", $sformatf("dividend %0h divisor %0h", o_dividend, o_divisor));
            end else begin
                mon_e = exp_q.pop_front();
                check("hs_dividend", o_dividend, mon_e[15:8]);
                check("hs_divisor", o_divisor, mon_e[7:0]);
                check("hs_div_by_zero", o_div_by_zero, mon_e[16]);
                exp_cnt = exp_cnt + 8'd1;
            end
            @(posedge clk);
            #1;
            check("frame_count", o_frame_count, exp_cnt);
            check("valid_drop", o_valid, 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, o_valid, 32'd0);
        check({tag, "_timeout"}, o_timeout, 32'd0);
        check({tag, "_dbz"}, o_div_by_zero, 32'd0);
        check({tag, "_dividend"}, o_dividend, 32'd0);
        check({tag, "_divisor"}, o_divisor, 32'd0);
        check({tag, "_count"}, o_frame_count, 32'd0);
        check({tag, "_ready"}, o_ready, 32'd0);
        check({tag, "_state"}, o_fsm_state, S_WDD);
    endtask

    initial begin
        int pulse_at;
        int t0;
        bit saw_valid;
        logic [7:0] a, b;

        vecs[0] = '{8'h25, 8'h00, 0, 0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 3, 2, 1'b0};
        vecs[2] = '{8'h01, 8'hFF, 1, 0, 1'b0};
        vecs[3] = '{8'hA5, 8'h5A, 0, 4, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 2, 1, 1'b1};
        vecs[5] = '{8'h80, 8'h7F, TO - 2, 0, 1'b0};

        // Reset values, then an accept on the very first edge after release.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n   = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h30;
        i_ready = 1'b1;
        #1;
        check("ready_after_reset", o_ready, 32'd1);
        exp_q.push_back({1'b0, 8'h30, 8'h10});
        tick();
        check("first_accept_state", o_fsm_state, S_WDS);
        i_data = 8'h10;
        tick();
        i_valid = 1'b0;
        check("b2b_valid", o_valid, 32'd1);
        check("b2b_ready_low", o_ready, 32'd0);
        tick();
        check("b2b_count", o_frame_count, 32'd1);
        i_ready = 1'b0;

        // Table-driven pairs with idle gaps and downstream back-pressure.
        foreach (vecs[i]) begin
            send_byte(vecs[i].dividend);
            repeat (vecs[i].gap) tick();
            exp_q.push_back({vecs[i].exp_dbz, vecs[i].dividend, vecs[i].divisor});
            send_byte(vecs[i].divisor);
            check("vec_valid", o_valid, 32'd1);
            check("vec_dbz", o_div_by_zero, vecs[i].exp_dbz);
            for (int k = 0; k < vecs[i].hold; k++) begin
                tick();
                check("hold_valid", o_valid, 32'd1);
                check("hold_dividend", o_dividend, vecs[i].dividend);
                check("hold_divisor", o_divisor, vecs[i].divisor);
            end
            await_drain();
        end

        // Dividend followed by TO idle cycles: one timeout pulse on the TO-th cycle.
        t0 = n_tmo;
        pulse_at = -1;
        saw_valid = 1'b0;
        send_byte(8'h40);
        for (int c = 1; c <= TO + 3; c++) begin
            tick();
            if (o_timeout === 1'b1 && pulse_at < 0) pulse_at = c;
            if (o_valid !== 1'b0) saw_valid = 1'b1;
        end
        check("timeout_cycle", pulse_at, TO);
        check("timeout_pulses", n_tmo - t0, 32'd1);
        check("timeout_no_valid", saw_valid, 32'd0);
        check("timeout_state", o_fsm_state, S_WDD);

        // Divisor on the threshold cycle is accepted, no timeout.
        t0 = n_tmo;
        send_byte(8'h66);
        repeat (TO - 1) tick();
        exp_q.push_back({1'b0, 8'h66, 8'h33});
        send_byte(8'h33);
        check("thresh_valid", o_valid, 32'd1);
        check("thresh_no_timeout", o_timeout, 32'd0);
        await_drain();
        tick();
        check("thresh_pulses", n_tmo - t0, 32'd0);

        // Stray bytes while PRESENT are neither captured nor disturb the pair.
        send_pair(8'h12, 8'h34, 0);
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1;
            i_data  = 8'($urandom_range(0, 255));
            tick();
            check("stray_ready", o_ready, 32'd0);
            check("stray_valid", o_valid, 32'd1);
            check("stray_dividend", o_dividend, 32'h12);
            check("stray_divisor", o_divisor, 32'h34);
        end
        i_data  = 8'hEE;
        i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("stray_hs_state", o_fsm_state, S_WDD);
        tick();
        check("stray_not_captured", o_fsm_state, S_WDD);
        check("stray_queue", exp_q.size(), 32'd0);

        // Reset in WAIT_DIVISOR drops the dividend quietly.
        t0 = n_tmo;
        send_byte(8'h55);
        @(negedge clk);
        rst_n = 1'b0;
        exp_cnt = 8'h00;
        #1;
        check_reset_outputs("rst_wds");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in PRESENT: immediate clear, no handshake, then 256 frames to wrap the count.
        send_pair(8'h77, 8'h88, 0);
        check("pre_rst_valid", o_valid, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        exp_cnt = 8'h00;
        #1;
        check_reset_outputs("rst_present");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_no_timeout", n_tmo - t0, 32'd0);
        for (int f = 0; f < 256; f++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            send_pair(a, b, 0);
            await_drain();
            if (f == 254) check("count_255", o_frame_count, 32'hFF);
        end
        check("count_wrap", o_frame_count, 32'h00);
        check("final_queue", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
